// File: rtl/ped_crossing_ctrl.sv
// Pedestrian crossing controller: latches button requests, grants a walk interval
// at the start of vehicle red, flashes DON'T-WALK on clearance, and traps non-one-hot lights.
module ped_crossing_ctrl #(
  parameter int unsigned WALK_CYCLES  = 8,
  parameter int unsigned CLEAR_CYCLES = 4,
  parameter int unsigned BLINK_DIV    = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic red_i,
  input  logic yellow_i,
  input  logic green_i,
  input  logic ped_btn,
  output logic walk,
  output logic dont_walk,
  output logic req_pending,
  output logic fault
);

  localparam int unsigned MAX_CYC = (WALK_CYCLES > CLEAR_CYCLES) ? WALK_CYCLES : CLEAR_CYCLES;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);
  localparam int unsigned DW      = $clog2(BLINK_DIV + 1);

  localparam logic [CW-1:0] WALK_LOAD  = CW'(WALK_CYCLES - 1);
  localparam logic [CW-1:0] CLEAR_LOAD = CW'(CLEAR_CYCLES - 1);
  localparam logic [DW-1:0] DIV_LAST   = DW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    WALK,
    CLEAR,
    FAULT
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] div_q, div_d;
  logic          blink_q, blink_d;
  logic          red_q, red_d;
  logic          req_pending_q, req_pending_d;
  logic          red_rise;
  logic          onehot_ok;
  logic          grant;

  assign red_rise  = red_i & ~red_q;
  assign onehot_ok = ({red_i, yellow_i, green_i} == 3'b100) ||
                     ({red_i, yellow_i, green_i} == 3'b010) ||
                     ({red_i, yellow_i, green_i} == 3'b001);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      div_q         <= '0;
      blink_q       <= 1'b0;
      red_q         <= 1'b0;
      req_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      div_q         <= div_d;
      blink_q       <= blink_d;
      red_q         <= red_d;
      req_pending_q <= req_pending_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    blink_d = blink_q;
    red_d   = red_i;
    grant   = 1'b0;
    if (!onehot_ok) begin
      state_d = FAULT;
    end else begin
      case (state_q)
        IDLE: begin
          if (red_rise && (req_pending_q || ped_btn)) begin
            state_d = WALK;
            cnt_d   = WALK_LOAD;
            grant   = 1'b1;
          end
        end
        WALK: begin
          if (!red_i) begin
            state_d = IDLE;
          end else if (cnt_q == '0) begin
            state_d = CLEAR;
            cnt_d   = CLEAR_LOAD;
            blink_d = 1'b1;
            div_d   = '0;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        CLEAR: begin
          if (!red_i || (cnt_q == '0)) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - CW'(1);
            if (div_q == DIV_LAST) begin
              div_d   = '0;
              blink_d = ~blink_q;
            end else begin
              div_d = div_q + DW'(1);
            end
          end
        end
        FAULT:   state_d = FAULT;
        default: state_d = IDLE;
      endcase
    end
  end

  // A press in the granting cycle re-arms the request for the next red phase.
  assign req_pending_d = ped_btn | (req_pending_q & ~grant);

  always_comb begin
    dont_walk = 1'b1;
    case (state_q)
      WALK:    dont_walk = 1'b0;
      CLEAR:   dont_walk = blink_q;
      default: dont_walk = 1'b1;
    endcase
  end

  assign walk        = (state_q == WALK) & red_i;
  assign req_pending = req_pending_q;
  assign fault       = (state_q == FAULT);

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Vector-table bench for ped_crossing_ctrl with default parameters; each record gives
// one cycle of inputs and the outputs expected during that cycle.
module tb_ped_crossing_ctrl;

  logic clk;
  logic rst_n;
  logic red_i, yellow_i, green_i, ped_btn;
  logic walk, dont_walk, req_pending, fault;

  ped_crossing_ctrl #(
    .WALK_CYCLES (8),
    .CLEAR_CYCLES(4),
    .BLINK_DIV   (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .red_i      (red_i),
    .yellow_i   (yellow_i),
    .green_i    (green_i),
    .ped_btn    (ped_btn),
    .walk       (walk),
    .dont_walk  (dont_walk),
    .req_pending(req_pending),
    .fault      (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lights {red, yellow, green}
  localparam bit [2:0] R = 3'b100;
  localparam bit [2:0] Y = 3'b010;
  localparam bit [2:0] G = 3'b001;

  // Expected outputs {walk, dont_walk, req_pending, fault}
  localparam bit [3:0] IDL  = 4'b0100;
  localparam bit [3:0] IDLR = 4'b0110;
  localparam bit [3:0] WLK  = 4'b1000;
  localparam bit [3:0] WLKR = 4'b1010;
  localparam bit [3:0] DW0  = 4'b0000;
  localparam bit [3:0] DW0R = 4'b0010;
  localparam bit [3:0] FLT  = 4'b0101;
  localparam bit [3:0] FLTR = 4'b0111;

  typedef struct {
    string    name;
    bit       rst_n;
    bit [2:0] lit;
    bit       btn;
    bit [3:0] exp;
  } vec_t;

  vec_t     vecs[$];
  bit [3:0] exp_q[$];
  string    name_q[$];
  int       checks = 0;
  int       errors = 0;

  function automatic void add_n(int n, string nm, bit rn, bit [2:0] l, bit b, bit [3:0] e);
    vec_t v;
    v.name  = nm;
    v.rst_n = rn;
    v.lit   = l;
    v.btn   = b;
    v.exp   = e;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endfunction

  function automatic void add(string nm, bit rn, bit [2:0] l, bit b, bit [3:0] e);
    add_n(1, nm, rn, l, b, e);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit [3:0] got, exp;
    string    nm;

    rst_n    = 1'b0;
    red_i    = 1'b1;
    yellow_i = 1'b0;
    green_i  = 1'b1;
    ped_btn  = 1'b1;

    // Reset with illegal lights and a pressed button
    add_n(2, "reset", 0, R | G, 1, IDL);
    // Full crossing
    add("idle", 1, G, 0, IDL);
    add("btn_green", 1, G, 1, IDL);
    add("req_latched", 1, G, 0, IDLR);
    add("req_yellow", 1, Y, 0, IDLR);
    add("red_rise", 1, R, 0, IDLR);
    add_n(8, "walk", 1, R, 0, WLK);
    add_n(2, "clear_on", 1, R, 0, IDL);
    add_n(2, "clear_off", 1, R, 0, DW0);
    add_n(7, "after_clear", 1, R, 0, IDL);
    // Late request within a red phase
    add("late_yel", 1, Y, 0, IDL);
    add("late_grn", 1, G, 0, IDL);
    add_n(2, "red_noreq", 1, R, 0, IDL);
    add("late_btn", 1, R, 1, IDL);
    add_n(3, "late_hold", 1, R, 0, IDLR);
    add("late_yel2", 1, Y, 0, IDLR);
    add("late_grn2", 1, G, 0, IDLR);
    add("late_rise", 1, R, 0, IDLR);
    add("late_walk", 1, R, 0, WLK);
    add("walk2", 1, R, 0, WLK);
    // Abort on the third walk cycle
    add("abort", 1, G, 0, DW0);
    add("abort_idle", 1, G, 0, IDL);
    add("abort_grn", 1, G, 0, IDL);
    // Press in the granting cycle is kept for the next phase
    add("grant_btn", 1, R, 1, IDL);
    add("set_wins", 1, R, 0, WLKR);
    add("abort2", 1, G, 0, DW0R);
    add("held", 1, G, 0, IDLR);
    add("held_yel", 1, Y, 0, IDLR);
    add("held_rise", 1, R, 0, IDLR);
    add("served", 1, R, 0, WLK);
    // Fault is sticky until reset
    add("nonhot", 1, R | G, 0, WLK);
    add("fault", 1, R, 0, FLT);
    add("fault_btn", 1, R, 1, FLT);
    add("fault_grn", 1, G, 0, FLTR);
    add("fault_rise", 1, R, 0, FLTR);
    add("fault_hold", 1, R, 0, FLTR);
    add("fault_rst", 0, R, 0, FLTR);
    add("fault_clr", 1, G, 0, IDL);
    // Five light cycles without any request
    for (int k = 0; k < 5; k++) begin
      add_n(3, "noreq_red", 1, R, 0, IDL);
      add_n(2, "noreq_grn", 1, G, 0, IDL);
      add("noreq_yel", 1, Y, 0, IDL);
    end
    // Red held through reset counts as a rising edge afterwards
    add("rst_red", 0, R, 0, IDL);
    add("post_rst_rise", 1, R, 1, IDL);
    add("post_rst_walk", 1, R, 0, WLKR);
    add("abort3", 1, Y, 0, DW0R);
    add("end", 1, G, 0, IDLR);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      rst_n                        = vecs[i].rst_n;
      {red_i, yellow_i, green_i}   = vecs[i].lit;
      ped_btn                      = vecs[i].btn;
      exp_q.push_back(vecs[i].exp);
      name_q.push_back(vecs[i].name);
      @(negedge clk);
      got = {walk, dont_walk, req_pending, fault};
      exp = exp_q.pop_front();
      nm  = name_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s[%0d]: walk/dont_walk/req/fault got %b required %b", nm, i, got, exp);
      end
      checks++;
      if ((walk & ~red_i) !== 1'b0) begin
        errors++;
        $display("FAIL %s[%0d]: walk without red got walk=%b red=%b", nm, i, walk, red_i);
      end
    end

    if (checks != 2 * vecs.size()) begin
      errors++;
      $display("FAIL completeness: got %0d checks required %0d", checks, 2 * vecs.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ped_crossing_ctrl.md
# ped_crossing_ctrl

Pedestrian crossing controller placed directly downstream of the vehicle traffic-light FSM. It consumes the one-hot red/yellow/green phase outputs, latches pedestrian button requests, and drives the WALK / DON'T-WALK signal heads. A walk interval is granted only at the start of a vehicle red phase. Walk is never shown unless vehicle red is asserted in the same cycle. A sticky fault is raised if the light inputs stop being one-hot.

## Interface
- WALK_CYCLES, default 8: number of cycles WALK is shown; must be ≥1.
- CLEAR_CYCLES, default 4: number of cycles of flashing DON'T-WALK after WALK; must be ≥1.
- BLINK_DIV, default 2: half-period of the flashing DON'T-WALK in cycles; must be ≥1.
- clk  input  1  clock.
- rst_n  input  1  reset, synchronous, active-low.
- red_i  input  1  vehicle red from the light FSM.
- yellow_i  input  1  vehicle yellow from the light FSM.
- green_i  input  1  vehicle green from the light FSM.
- ped_btn  input  1  pedestrian request, already synchronised; any high cycle is a request.
- walk  output  1  WALK lamp.
- dont_walk  output  1  DON'T-WALK lamp, steady or flashing.
- req_pending  output  1  a request is latched and not yet served.
- fault  output  1  sticky input-consistency fault.

## Operation
- States: IDLE, WALK, CLEAR, FAULT.
- Internal registers: red_q, the previous red_i, reset to 0; a down-counter of width clog2(max(WALK_CYCLES, CLEAR_CYCLES)+1); a blink divider and a blink phase bit.
- red_rise = red_i & ~red_q. Because red_q resets to 0, a red_i that is high in the first cycle after reset counts as a rising edge.
- onehot_ok = exactly one of red_i, yellow_i, green_i is high.
- req_pending:
  - Set in any cycle with ped_btn=1.
  - Cleared on the IDLE→WALK transition.
  - If ped_btn=1 in the same cycle as that transition, the set wins, so the request is held for the next red phase.
- Transitions, in priority order:
  - Any state, !onehot_ok → FAULT.
  - FAULT → FAULT until reset.
  - IDLE, red_rise & (req_pending | ped_btn) → WALK. Counter loads WALK_CYCLES-1.
  - WALK, !red_i → IDLE (abort).
  - WALK, counter==0 → CLEAR. Counter loads CLEAR_CYCLES-1; blink phase set to 1; divider cleared.
  - WALK, otherwise: decrement the counter.
  - CLEAR, !red_i → IDLE.
  - CLEAR, counter==0 → IDLE.
  - CLEAR, otherwise: decrement the counter. The blink phase toggles every BLINK_DIV cycles.
- A request arriving after red_rise within the same red phase is not served in that phase. It waits for the next red_rise.
- Outputs:
  - walk = (state==WALK) & red_i. This is the only combinational path, and it guarantees walk is never high without red.
  - dont_walk = 1 in IDLE and FAULT; 0 in WALK; equal to the blink phase in CLEAR.
  - fault = (state==FAULT).
  - req_pending is a register.
- Reset mid-operation returns to IDLE, with every register at its reset value, on the next edge.

## Timing
- Reset values: state IDLE, walk=0, dont_walk=1, req_pending=0, fault=0, red_q=0.
- Walk latency:
  - red_rise in cycle N with a request → walk=1 from cycle N+1 through N+WALK_CYCLES, provided red_i stays high.
  - CLEAR then occupies N+WALK_CYCLES+1 through N+WALK_CYCLES+CLEAR_CYCLES.
  - dont_walk is steady 1 afterwards.
- Blink: the first CLEAR cycle shows 1. The lamp toggles after every BLINK_DIV cycles.
- Abort: red_i falls in cycle M during WALK → walk=0 in cycle M (combinational), and the state is IDLE from M+1. The request is considered served and is not re-latched.
- Fault: first non-one-hot cycle F → fault=1 and walk=0 from F+1. Cleared only by rst_n.
- The upstream light FSM must hold red for ≥ WALK_CYCLES+CLEAR_CYCLES+1 cycles for a full crossing. A shorter red aborts.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with arbitrary inputs → walk=0, dont_walk=1, req_pending=0, fault=0.
- Full crossing with defaults:
  - Stimulus: ped_btn pulsed 1 cycle during green; red_i rises at cycle N and is held 20 cycles.
  - req_pending=1 until N+1.
  - walk=1 over N+1..N+8.
  - dont_walk over N+9..N+12 = 1,1,0,0.
  - dont_walk=1 steady from N+13.
- Late request: ped_btn pulsed at the third cycle of a red phase → no walk in that phase; req_pending stays 1; walk asserts one cycle after the next red rise.
- Abort: red_i drops at the third WALK cycle → walk=0 in that same cycle, dont_walk=1 the next cycle, req_pending=0.
- Fault:
  - Drive red_i=green_i=1 for 1 cycle → fault=1 next cycle.
  - fault stays 1 after the inputs return to one-hot, and button presses never produce walk.
  - rst_n clears the fault.
- No request: 5 full red/green/yellow cycles with ped_btn=0 → walk never asserted, dont_walk=1 throughout.
